counter_sweep_ctrl: RTL and testbench

COUNTER_SWEEP_CTRL -- requirements
Module: counter_sweep_ctrl

---
 rtl/counter_sweep_pkg.sv | 23 ++
 rtl/updown_count4.sv | 38 +++
 rtl/counter_sweep_ctrl.sv | 156 +++++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sweep_pkg.sv
// counter_sweep_pkg -- shared types and constants for the sweep controller.
//   CNT_W          : counter width (4)
//   DIR_UP/DIR_DOWN: direction encodings for cmd_dir / latched direction
//   state_t        : controller FSM states (IDLE, RUN)
//   is_wrap()      : true when a step from 'cur' in direction 'up' crosses
//                    the 15<->0 boundary
package counter_sweep_pkg;

  localparam int CNT_W = 4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic is_wrap(input logic [CNT_W-1:0] cur, input logic up);
    return up ? (cur == {CNT_W{1'b1}}) : (cur == '0);
  endfunction

endpackage

// File: rtl/updown_count4.sv
// updown_count4 -- 4-bit loadable up/down counter with a registered wrap flag.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (count=0, wrap_pulse=0)
//   load        : load load_val into count (wins over en, never flags wrap)
//   load_val    : value loaded on load
//   en          : step count by one in direction 'up' (1=up, 0=down), mod 16
//   up          : step direction
//   count       : current count (registered)
//   wrap_pulse  : one-cycle pulse in the cycle after a 15->0 or 0->15 step
module updown_count4
  import counter_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [CNT_W-1:0] count,
  output logic             wrap_pulse
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (load) begin
        count <= load_val;
      end else if (en) begin
        count      <= up ? count + 1'b1 : count - 1'b1;
        wrap_pulse <= is_wrap(count, up);
      end
    end
  end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl -- sweeps a 4-bit counter from a start value to a target
// value in a commanded direction, with pause and abort.
// Optional feature macro: SWEEP_PINGPONG_EN -- when defined, cmd_reps is
// latched and each target hit with reversals left bounces the sweep back
// toward the original start value instead of finishing.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake; ready only while IDLE
//   cmd_start/cmd_target  : count loaded at acceptance / count ending sweep
//   cmd_dir               : 1=up, 0=down
//   cmd_reps              : ping-pong reversals (ignored unless feature on)
//   pause                 : hold everything while high in RUN
//   abort                 : end the active sweep next edge (beats pause/target)
//   count                 : current counter value
//   busy                  : high while not IDLE
//   done/aborted          : one-cycle completion pulses
//   wrap                  : one-cycle pulse after a 15->0 or 0->15 step
module counter_sweep_ctrl
  import counter_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_start,
  input  logic [CNT_W-1:0] cmd_target,
  input  logic             cmd_dir,
  input  logic [3:0]       cmd_reps,
  input  logic             pause,
  input  logic             abort,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             wrap
);

  state_t           state_q, state_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic             accept;
  logic             at_tgt;
  logic             reverse;
  logic             cnt_load, cnt_en, cnt_up;
  logic             done_d, aborted_d;

`ifdef SWEEP_PINGPONG_EN
  logic [CNT_W-1:0] start_q;
  logic [3:0]       reps_q, reps_d;

  assign reverse = (reps_q != 4'd0);
`else
  logic unused_reps;

  assign unused_reps = ^cmd_reps;
  assign reverse     = 1'b0;
`endif

  assign accept = cmd_valid && cmd_ready;
  assign at_tgt = (count == tgt_q);

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    tgt_d     = tgt_q;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_up    = dir_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
`ifdef SWEEP_PINGPONG_EN
    reps_d    = reps_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = RUN;
          dir_d    = cmd_dir;
          tgt_d    = cmd_target;
          cnt_load = 1'b1;
`ifdef SWEEP_PINGPONG_EN
          reps_d   = cmd_reps;
`endif
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (!pause) begin
          if (at_tgt && reverse) begin
            // Bounce: turn around on the same edge and take the first step
            // of the return leg so the target value is not seen twice.
            dir_d  = ~dir_q;
            cnt_up = ~dir_q;
            cnt_en = 1'b1;
`ifdef SWEEP_PINGPONG_EN
            tgt_d  = start_q;
            reps_d = reps_q - 4'd1;
`endif
          end else if (at_tgt) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      dir_q     <= DIR_UP;
      tgt_q     <= '0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      tgt_q     <= tgt_d;
      busy      <= (state_d != IDLE);
      cmd_ready <= (state_d == IDLE);
      done      <= done_d;
      aborted   <= aborted_d;
    end
  end

`ifdef SWEEP_PINGPONG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q <= '0;
      reps_q  <= 4'd0;
    end else begin
      if (accept) start_q <= cmd_start;
      reps_q <= reps_d;
    end
  end
`endif

  updown_count4 u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_val   (cmd_start),
    .en         (cnt_en),
    .up         (cnt_up),
    .count      (count),
    .wrap_pulse (wrap)
  );

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
module tb_counter_sweep_ctrl;
  import counter_sweep_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_dir = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] cmd_start = '0;
  logic [3:0] cmd_target = '0;
  logic [3:0] cmd_reps = '0;
  logic       cmd_ready, busy, done, aborted, wrap;
  logic [3:0] count;

  counter_sweep_ctrl dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_target(cmd_target), .cmd_dir(cmd_dir),
    .cmd_reps(cmd_reps), .pause(pause), .abort(abort), .count(count),
    .busy(busy), .done(done), .aborted(aborted), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // kind: 0 = done, 1 = aborted; lat = edges from acceptance to pulse edge
  typedef struct {
    int kind;
    int cnt;
    int lat;
    int wraps;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: list every value the counter passes through (ignoring pause),
  // then place pause/abort on that timeline.
  task automatic model(input int s, t, d, r, ps, pl, ab, output exp_t x);
    int path[$];
    int p, dd, L, ov, idx;
    p  = s;
    dd = d;
    path.push_back(p);
    while (p != t) begin
      p = dd ? (p + 1) % 16 : (p + 15) % 16;
      path.push_back(p);
    end
`ifdef SWEEP_PINGPONG_EN
    for (int k = 0; k < r; k++) begin
      dd = 1 - dd;
      p  = dd ? (p + 1) % 16 : (p + 15) % 16;
      path.push_back(p);
      while (p != s) begin
        p = dd ? (p + 1) % 16 : (p + 15) % 16;
        path.push_back(p);
      end
    end
`endif
    L     = path.size();
    x.lat = (pl > 0 && ps >= 1 && ps <= L) ? L + pl : L;
    if (ab >= 1 && ab <= x.lat) begin
      ov = 0;
      for (int e = 1; e < ab; e++) if (pl > 0 && e >= ps && e < ps + pl) ov++;
      idx    = (ab - 1) - ov;
      x.kind = 1;
      x.lat  = ab;
    end else begin
      idx    = L - 1;
      x.kind = 0;
    end
    x.cnt   = path[idx];
    x.wraps = 0;
    for (int i = 1; i <= idx; i++)
      if ((path[i-1] == 15 && path[i] == 0) || (path[i-1] == 0 && path[i] == 15))
        x.wraps++;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!cmd_ready && w < 200) begin
      tick();
      w++;
    end
    chk("ready_timeout", int'(cmd_ready), 1);
  endtask

  task automatic run_cmd(input int s, t, d, r, ps, pl, ab);
    exp_t x;
    wait_ready();
    model(s, t, d, r, ps, pl, ab, x);
    sb.push_back(x);
    cmd_start  = 4'(s);
    cmd_target = 4'(t);
    cmd_dir    = d[0];
    cmd_reps   = 4'(r);
    pause      = 1'b0;
    abort      = 1'b0;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int e = 1; e <= x.lat; e++) begin
      pause      = (pl > 0 && e >= ps && e < ps + pl);
      abort      = (e == ab);
      // junk commands while busy must be ignored
      cmd_valid  = 1'($urandom_range(0, 1));
      cmd_start  = 4'($urandom_range(0, 15));
      cmd_target = 4'($urandom_range(0, 15));
      tick();
    end
    pause     = 1'b0;
    abort     = 1'b0;
    cmd_valid = 1'b0;
  endtask

  // Monitor: pops one expectation per done/aborted pulse.
  initial begin : mon
    bit   trk;
    int   acc;
    int   wr;
    exp_t e;
    trk = 0;
    acc = 0;
    wr  = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        trk = 0;
        wr  = 0;
      end else begin
        if (trk && wrap) wr++;
        if (!trk) chk("wrap_idle", int'(wrap), 0);
        if (done || aborted) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse done=%0b aborted=%0b expected none", done, aborted);
          end else begin
            e = sb.pop_front();
            chk("kind", int'(aborted), e.kind);
            chk("done_and_aborted", int'(done && aborted), 0);
            chk("end_count", int'(count), e.cnt);
            chk("latency", edge_n - acc, e.lat);
            chk("wraps", wr, e.wraps);
            chk("busy_after", int'(busy), 0);
          end
          trk = 0;
          wr  = 0;
        end
        if (cmd_valid && cmd_ready) begin
          trk = 1;
          acc = edge_n + 1;
          wr  = 0;
        end
      end
    end
  end

  initial begin : stim
    int s, t, d, r, ps, pl, ab, w;
    repeat (3) tick();
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_aborted", int'(aborted), 0);
    chk("rst_wrap", int'(wrap), 0);
    reset = 1'b0;
    tick();

    run_cmd(3, 7, 1, 0, 0, 0, 0);
    run_cmd(14, 1, 1, 0, 0, 0, 0);
    run_cmd(2, 2, 0, 0, 0, 0, 0);
    run_cmd(0, 9, 1, 0, 5, 3, 0);
    run_cmd(0, 9, 1, 0, 6, 1, 6);
    run_cmd(1, 14, 0, 0, 0, 0, 0);
`ifdef SWEEP_PINGPONG_EN
    run_cmd(0, 2, 1, 1, 0, 0, 0);
    run_cmd(3, 7, 1, 0, 0, 0, 0);
`endif

    // abort while idle is ignored
    tick();
    abort = 1'b1;
    repeat (2) tick();
    abort = 1'b0;
    tick();

    for (int n = 0; n < 60; n++) begin
      s  = $urandom_range(0, 15);
      t  = $urandom_range(0, 15);
      d  = $urandom_range(0, 1);
      r  = $urandom_range(0, 2);
      pl = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
      ps = $urandom_range(1, 20);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 25) : 0;
      run_cmd(s, t, d, r, ps, pl, ab);
      if ($urandom_range(0, 2) == 0) tick();
    end

    w = 0;
    while (sb.size() != 0 && w < 50) begin
      tick();
      w++;
    end
    chk("drain", sb.size(), 0);

    // reset in the middle of a sweep
    wait_ready();
    cmd_start  = 4'd0;
    cmd_target = 4'd9;
    cmd_dir    = 1'b1;
    cmd_reps   = 4'd0;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    chk("mid_count", int'(count), 3);
    chk("mid_busy", int'(busy), 1);
    reset = 1'b1;
    tick();
    chk("mrst_count", int'(count), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_ready", int'(cmd_ready), 1);
    chk("mrst_done", int'(done), 0);
    chk("mrst_aborted", int'(aborted), 0);
    reset = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
